// File: rtl/poly_addsub_stream.sv
// Streaming coefficient-wise polynomial add/sub: raw add, add mod Q, sub mod Q.
// Beats of LANES coefficients flow through a two-stage pipeline under valid/ready control.
module poly_addsub_stream #(
    parameter int          N     = 256,
    parameter int          LANES = 4,
    parameter int          W     = 32,
    parameter int unsigned Q     = 8380417
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] a_in,
    input  logic [LANES*W-1:0] b_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] c_out,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               range_err
);

    localparam int             BEATS     = N / LANES;
    localparam int             CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BEATS - 1);
    localparam logic [W:0]     Q_X       = (W + 1)'(Q);
    localparam logic [W-1:0]   Q_W       = W'(Q);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q;
    logic [1:0]    mode_q;
    logic [CW-1:0] in_cnt_q;
    logic [CW-1:0] out_cnt_q;
    logic          range_err_q;
    logic          done_q;
    logic          s1_valid_q;
    logic          out_valid_q;

    logic             adv;
    logic             accept;
    logic             out_fire;
    logic [LANES-1:0] lane_err;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = (state_q == RUN) && adv;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && (out_cnt_q == LAST_BEAT);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign range_err = range_err_q;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [W-1:0] a_l;
            logic [W-1:0] b_l;
            logic [W:0]   sum_w;
            logic [W:0]   dif_w;
            logic [W-1:0] raw_d;
            logic         corr_d;
            logic [W-1:0] raw_q;
            logic         corr_q;
            logic [W-1:0] fix_w;
            logic [W-1:0] c_d;
            logic [W-1:0] c_q;

            assign a_l   = a_in[W*gi +: W];
            assign b_l   = b_in[W*gi +: W];
            assign sum_w = {1'b0, a_l} + {1'b0, b_l};
            assign dif_w = {1'b0, a_l} - {1'b0, b_l};
            assign raw_d = (mode_q == 2'd2) ? dif_w[W-1:0] : sum_w[W-1:0];
            // Correction decision is made in stage 1 from the full W+1 bit result.
            assign corr_d = (mode_q == 2'd1) ? (sum_w >= Q_X) :
                            (mode_q == 2'd2) ? dif_w[W] : 1'b0;
            assign fix_w  = (mode_q == 2'd2) ? (raw_q + Q_W) : (raw_q - Q_W);
            assign c_d    = corr_q ? fix_w : raw_q;

            assign lane_err[gi]      = (a_l >= Q_W) || (b_l >= Q_W);
            assign c_out[W*gi +: W]  = c_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    raw_q  <= '0;
                    corr_q <= 1'b0;
                    c_q    <= '0;
                end else if (adv) begin
                    if (accept) begin
                        raw_q  <= raw_d;
                        corr_q <= corr_d;
                    end
                    if (s1_valid_q) begin
                        c_q <= c_d;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 2'd0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            range_err_q <= 1'b0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (adv) begin
                s1_valid_q  <= accept;
                out_valid_q <= s1_valid_q;
            end
            // Counters saturate at the last beat so they never wrap mid-operation.
            if (accept && in_cnt_q != LAST_BEAT) begin
                in_cnt_q <= in_cnt_q + 1'b1;
            end
            if (out_fire && out_cnt_q != LAST_BEAT) begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end
            if (accept && mode_q != 2'd0 && |lane_err) begin
                range_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        mode_q      <= (mode == 2'd3) ? 2'd0 : mode;
                        in_cnt_q    <= '0;
                        out_cnt_q   <= '0;
                        range_err_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept && in_cnt_q == LAST_BEAT) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire && out_cnt_q == LAST_BEAT) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_addsub_stream.sv
// Randomized bench for poly_addsub_stream: drives whole polynomials with random
// valid/ready patterns and compares every beat against an arithmetic reference.
module tb_poly_addsub_stream;

    localparam int          N     = 256;
    localparam int          LANES = 4;
    localparam int          W     = 32;
    localparam int unsigned Q     = 8380417;
    localparam int          BEATS = N / LANES;
    localparam int          VW    = LANES * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] a_in;
    logic [VW-1:0] b_in;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] c_out;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          range_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] a_arr [N];
    logic [W-1:0] b_arr [N];

    poly_addsub_stream #(.N(N), .LANES(LANES), .W(W), .Q(Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference arithmetic on plain 64-bit integers.
    function automatic logic [W-1:0] ref_c(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint s;
        sa = longint'(a);
        sb = longint'(b);
        case (m)
            1: begin
                s = sa + sb;
                if (s >= longint'(Q)) s = s - longint'(Q);
            end
            2: begin
                s = sa - sb;
                if (s < 0) s = s + longint'(Q);
            end
            default: s = sa + sb;
        endcase
        return s[W-1:0];
    endfunction

    task automatic fill(input int m);
        for (int i = 0; i < N; i++) begin
            if (m == 1 || m == 2) begin
                a_arr[i] = $urandom_range(Q - 1);
                b_arr[i] = $urandom_range(Q - 1);
            end else begin
                a_arr[i] = $urandom();
                b_arr[i] = $urandom();
            end
        end
    endtask

    task automatic drive_beat(input bit vld, input int idx);
        for (int k = 0; k < LANES; k++) begin
            a_in[W*k +: W] = vld ? a_arr[idx*LANES + k] : $urandom();
            b_in[W*k +: W] = vld ? b_arr[idx*LANES + k] : $urandom();
        end
    endtask

    task automatic run_op(input int m, input int vp, input int rp, input int stall_at, input string name);
        bit            exp_err;
        bit            prev_stall;
        logic [VW-1:0] prev_c;
        logic [VW-1:0] exp_v;
        int            in_idx;
        int            out_idx;
        int            cyc;
        exp_err = 1'b0;
        if (m == 1 || m == 2) begin
            for (int i = 0; i < N; i++) begin
                if (a_arr[i] >= Q || b_arr[i] >= Q) exp_err = 1'b1;
            end
        end
        @(negedge clk);
        start     = 1'b1;
        mode      = m[1:0];
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_busy_start"}, VW'(busy), VW'(1'b1));
        check({name, "_rerr_clear"}, VW'(range_err), VW'(1'b0));
        check({name, "_ready_start"}, VW'(in_ready), VW'(1'b1));
        in_idx     = 0;
        out_idx    = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_c     = '0;
        while (out_idx < BEATS && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            in_valid = (in_idx < BEATS) && ($urandom_range(99) < vp);
            drive_beat(in_valid, in_idx);
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5)
                out_ready = 1'b0;
            else
                out_ready = ($urandom_range(99) < rp);
            #1;
            check({name, "_no_early_done"}, VW'(done), VW'(1'b0));
            if (prev_stall) begin
                check({name, "_stall_hold_c"}, c_out, prev_c);
                check({name, "_stall_hold_v"}, VW'(out_valid), VW'(1'b1));
            end
            if (out_valid) begin
                for (int k = 0; k < LANES; k++)
                    exp_v[W*k +: W] = ref_c(m, a_arr[out_idx*LANES + k], b_arr[out_idx*LANES + k]);
                check({name, "_beat"}, c_out, exp_v);
                check({name, "_last"}, VW'(out_last), VW'(out_idx == BEATS - 1));
                if (!out_ready) check({name, "_stall_inready"}, VW'(in_ready), VW'(1'b0));
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = c_out;
            if (out_valid && out_ready) out_idx++;
            if (in_valid && in_ready) in_idx++;
        end
        check({name, "_beat_count"}, VW'(out_idx), VW'(BEATS));
        @(posedge clk);
        #1;
        check({name, "_done"}, VW'(done), VW'(1'b1));
        check({name, "_busy_end"}, VW'(busy), VW'(1'b0));
        check({name, "_range_err"}, VW'(range_err), VW'(exp_err));
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, VW'(done), VW'(1'b0));
        check({name, "_rerr_sticky"}, VW'(range_err), VW'(exp_err));
        $display("op %s mode=%0d in=%0d out=%0d cycles=%0d", name, m, in_idx, out_idx, cyc);
    endtask

    task automatic abort_op();
        int acc;
        int cyc;
        fill(1);
        @(negedge clk);
        start     = 1'b1;
        mode      = 2'd1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        acc = 0;
        cyc = 0;
        while (acc < 3 && cyc < 50) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b1;
            drive_beat(1'b1, acc);
            cyc++;
            #1;
            if (in_ready) acc++;
        end
        check("abort_accepts", VW'(acc), VW'(3));
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", VW'(busy), VW'(1'b0));
        check("abort_out_valid", VW'(out_valid), VW'(1'b0));
        check("abort_done", VW'(done), VW'(1'b0));
        check("abort_in_ready", VW'(in_ready), VW'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done_after", VW'(done), VW'(1'b0));
        check("abort_valid_after", VW'(out_valid), VW'(1'b0));
        $display("op abort after %0d accepted beats", acc);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", VW'(in_ready), VW'(1'b0));
        check("rst_out_valid", VW'(out_valid), VW'(1'b0));
        check("rst_c_out", c_out, '0);
        check("rst_out_last", VW'(out_last), VW'(1'b0));
        check("rst_busy", VW'(busy), VW'(1'b0));
        check("rst_done", VW'(done), VW'(1'b0));
        check("rst_range_err", VW'(range_err), VW'(1'b0));
        @(negedge clk);
        rst = 1'b0;

        fill(1);
        a_arr[0] = Q - 1; b_arr[0] = 32'd2;
        a_arr[1] = 32'd5; b_arr[1] = 32'd7;
        run_op(1, 100, 100, -1, "addmod");

        fill(2);
        a_arr[0] = 32'd0; b_arr[0] = 32'd1;
        a_arr[1] = 32'd9; b_arr[1] = 32'd4;
        run_op(2, 70, 70, -1, "submod");

        fill(0);
        a_arr[0] = 32'h7FFF_FFFF; b_arr[0] = 32'd1;
        a_arr[1] = 32'hFFFF_FFFF; b_arr[1] = 32'd1;
        run_op(0, 80, 60, -1, "raw");

        fill(1);
        run_op(1, 100, 100, 10, "backpressure");

        abort_op();
        fill(0);
        run_op(3, 90, 90, -1, "after_abort");

        fill(1);
        a_arr[5] = Q;
        run_op(1, 85, 85, -1, "range");

        fill(2);
        run_op(2, 60, 50, 20, "sub_clear");

        fill(2);
        b_arr[9] = 32'hFFFF_FFFF;
        run_op(2, 90, 40, -1, "sub_range");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
